// File: rtl/parking_gate_ctrl.sv
// Parking-lot gate controller: arbitrates entry/exit button edges one car at a time,
// sequences the gate-open pulse and owns the remaining-space count.
module parking_gate_ctrl #(
    parameter int unsigned CAPACITY        = 12,
    parameter int unsigned GATE_CYCLES     = 4,
    parameter int unsigned COOLDOWN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    output logic [3:0] remain,
    output logic       entry_open,
    output logic       exit_open,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic [1:0] reject
);

    localparam int unsigned TimerMax = (GATE_CYCLES > COOLDOWN_CYCLES) ? GATE_CYCLES
                                                                        : COOLDOWN_CYCLES;
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    localparam logic [3:0]        Cap       = 4'(CAPACITY);
    localparam logic [TimerW-1:0] GateLoad  = TimerW'(GATE_CYCLES - 1);
    localparam logic [TimerW-1:0] CoolLoad  = TimerW'(COOLDOWN_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StEntryOpen,
        StExitOpen,
        StCooldown
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        remain_q, remain_d;
    logic              entry_open_q, entry_open_d;
    logic              exit_open_q, exit_open_d;
    logic [1:0]        reject_q, reject_d;
    logic              pend_entry_q, pend_entry_d;
    logic              pend_exit_q, pend_exit_d;
    logic              entry_hist_q, exit_hist_q;
    logic              last_grant_entry_q, last_grant_entry_d;

    logic entry_edge, exit_edge;
    logic clr_entry, clr_exit;
    logic pick_entry;

    assign entry_edge = entry_req & ~entry_hist_q;
    assign exit_edge  = exit_req & ~exit_hist_q;

    always_comb begin
        state_d            = state_q;
        timer_d            = timer_q;
        remain_d           = remain_q;
        entry_open_d       = entry_open_q;
        exit_open_d        = exit_open_q;
        reject_d           = 2'b00;
        last_grant_entry_d = last_grant_entry_q;
        clr_entry          = 1'b0;
        clr_exit           = 1'b0;
        pick_entry         = 1'b0;

        case (state_q)
            StIdle: begin
                if (pend_entry_q || pend_exit_q) begin
                    // On a tie, serve the direction that did not win last time.
                    pick_entry         = pend_entry_q && (!pend_exit_q || !last_grant_entry_q);
                    last_grant_entry_d = pick_entry;
                    if (pick_entry) begin
                        clr_entry = 1'b1;
                        if (remain_q == 4'd0) begin
                            reject_d = 2'b10;
                        end else begin
                            state_d      = StEntryOpen;
                            entry_open_d = 1'b1;
                            timer_d      = GateLoad;
                        end
                    end else begin
                        clr_exit = 1'b1;
                        if (remain_q == Cap) begin
                            reject_d = 2'b01;
                        end else begin
                            state_d     = StExitOpen;
                            exit_open_d = 1'b1;
                            timer_d     = GateLoad;
                        end
                    end
                end
            end
            StEntryOpen: begin
                if (timer_q == '0) begin
                    entry_open_d = 1'b0;
                    remain_d     = remain_q - 4'd1;
                    state_d      = StCooldown;
                    timer_d      = CoolLoad;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StExitOpen: begin
                if (timer_q == '0) begin
                    exit_open_d = 1'b0;
                    remain_d    = remain_q + 4'd1;
                    state_d     = StCooldown;
                    timer_d     = CoolLoad;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StCooldown: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d      = StIdle;
                entry_open_d = 1'b0;
                exit_open_d  = 1'b0;
                timer_d      = '0;
            end
        endcase

        // A fresh edge wins over a same-cycle clear.
        pend_entry_d = (pend_entry_q & ~clr_entry) | entry_edge;
        pend_exit_d  = (pend_exit_q & ~clr_exit) | exit_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            timer_q            <= '0;
            remain_q           <= Cap;
            entry_open_q       <= 1'b0;
            exit_open_q        <= 1'b0;
            reject_q           <= 2'b00;
            pend_entry_q       <= 1'b0;
            pend_exit_q        <= 1'b0;
            entry_hist_q       <= 1'b0;
            exit_hist_q        <= 1'b0;
            last_grant_entry_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            timer_q            <= timer_d;
            remain_q           <= remain_d;
            entry_open_q       <= entry_open_d;
            exit_open_q        <= exit_open_d;
            reject_q           <= reject_d;
            pend_entry_q       <= pend_entry_d;
            pend_exit_q        <= pend_exit_d;
            entry_hist_q       <= entry_req;
            exit_hist_q        <= exit_req;
            last_grant_entry_q <= last_grant_entry_d;
        end
    end

    assign remain     = remain_q;
    assign entry_open = entry_open_q;
    assign exit_open  = exit_open_q;
    assign reject     = reject_q;
    assign full       = (remain_q == 4'd0);
    assign empty      = (remain_q == Cap);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with CAPACITY=12, GATE_CYCLES=4, COOLDOWN_CYCLES=2.
module tb_parking_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic [3:0] remain;
    logic       entry_open;
    logic       exit_open;
    logic       full;
    logic       empty;
    logic       busy;
    logic [1:0] reject;

    int total = 0;
    int bad   = 0;

    parking_gate_ctrl #(
        .CAPACITY       (12),
        .GATE_CYCLES    (4),
        .COOLDOWN_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .remain    (remain),
        .entry_open(entry_open),
        .exit_open (exit_open),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .reject    (reject)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] obs, exp;
        do_reset();
        obs = {remain, empty, full, busy, entry_open, exit_open, reject[1]};
        exp = {4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", obs, exp);
        end
        total++;
        if (reject !== 2'b00) begin
            bad++;
            $display("FAIL reset_reject got=%b want=00", reject);
        end
    endtask

    task automatic test_exit_when_empty();
        exit_req = 1'b1;
        tick();                 // edge k
        exit_req = 1'b0;
        total++;
        if (reject !== 2'b00) begin
            bad++;
            $display("FAIL exit_reject_early got=%b want=00", reject);
        end
        tick();                 // k+1
        total++;
        if (reject !== 2'b01) begin
            bad++;
            $display("FAIL exit_reject_pulse got=%b want=01", reject);
        end
        for (int c = 2; c < 9; c++) begin
            tick();
            total++;
            if ({reject, exit_open, busy, remain} !== {2'b00, 1'b0, 1'b0, 4'd12}) begin
                bad++;
                $display("FAIL exit_reject_after cyc=%0d got rej=%b open=%b busy=%b rem=%0d",
                         c, reject, exit_open, busy, remain);
            end
        end
    endtask

    task automatic test_single_entry();
        logic [5:0] obs, exp;
        entry_req = 1'b1;
        tick();                 // edge k; held high for 20 cycles
        for (int c = 1; c <= 20; c++) begin
            tick();
            exp[5]   = (c >= 1 && c <= 4);
            exp[4]   = (c >= 1 && c <= 6);
            exp[3:0] = (c >= 5) ? 4'd11 : 4'd12;
            obs      = {entry_open, busy, remain};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL entry_seq cyc=%0d got open,busy,rem=%b want=%b", c, obs, exp);
            end
        end
        entry_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_tie_break();
        logic [7:0] obs, exp;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        tick();                 // edge k
        entry_req = 1'b0;
        exit_req  = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp[7]   = (c >= 1 && c <= 4);
            exp[6]   = (c >= 8 && c <= 11);
            exp[5]   = (c >= 1 && c <= 6) || (c >= 8 && c <= 13);
            exp[4]   = 1'b0;
            exp[3:0] = (c < 5) ? 4'd11 : ((c < 12) ? 4'd12 : 4'd11);
            obs      = {exit_open, entry_open, busy, reject[1] | reject[0], remain};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL tie_seq cyc=%0d got xo,eo,busy,rej,rem=%b want=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_fill_and_full();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            entry_req = 1'b1;
            tick();
            entry_req = 1'b0;
            for (int c = 0; c < 8; c++) tick();
            total++;
            if (remain !== 4'(12 - i)) begin
                bad++;
                $display("FAIL fill_remain car=%0d got=%0d want=%0d", i, remain, 12 - i);
            end
        end
        total++;
        if ({full, empty} !== 2'b10) begin
            bad++;
            $display("FAIL full_flag got full,empty=%b want=10", {full, empty});
        end
        entry_req = 1'b1;
        tick();
        entry_req = 1'b0;
        tick();
        total++;
        if (reject !== 2'b10) begin
            bad++;
            $display("FAIL entry_reject got=%b want=10", reject);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            total++;
            if ({entry_open, busy, reject, remain} !== {1'b0, 1'b0, 2'b00, 4'd0}) begin
                bad++;
                $display("FAIL full_after cyc=%0d got open=%b busy=%b rej=%b rem=%0d",
                         c, entry_open, busy, reject, remain);
            end
        end
    endtask

    task automatic test_reset_mid_open();
        do_reset();
        entry_req = 1'b1;
        tick();                 // k
        entry_req = 1'b0;
        tick();                 // k+1: gate opens
        total++;
        if (entry_open !== 1'b1) begin
            bad++;
            $display("FAIL midopen_open got=%b want=1", entry_open);
        end
        exit_req = 1'b1;
        tick();                 // k+2: exit queued, second open cycle
        exit_req = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({entry_open, busy, remain} !== {1'b0, 1'b0, 4'd12}) begin
            bad++;
            $display("FAIL midopen_reset got open=%b busy=%b rem=%0d want 0 0 12",
                     entry_open, busy, remain);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({exit_open, entry_open, busy, reject} !== 5'b0) begin
                bad++;
                $display("FAIL midopen_drop cyc=%0d got xo=%b eo=%b busy=%b rej=%b",
                         c, exit_open, entry_open, busy, reject);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        test_reset();
        test_exit_when_empty();
        test_single_entry();
        test_tie_break();
        test_fill_and_full();
        test_reset_mid_open();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
